// File: rtl/dff_pipe.sv
// Stallable, flushable register delay line: WIDTH-bit words through DEPTH stages with valid tracking.
// Optional tap mux on any stage when DFF_PIPE_TAP_EN is defined.
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_value,
  output logic [OCC_W-1:0] o_occupancy
`ifdef DFF_PIPE_TAP_EN
  ,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] i_tap_sel,
  output logic [WIDTH-1:0] o_tap_value,
  output logic             o_tap_valid
`endif
);

  if (DEPTH < 1 || DEPTH > 64 || WIDTH < 1) begin : g_bad_param
    $error("dff_pipe: illegal parameters WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
  end

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W:0]   occ_sum;

  // One extra bit so a full pipe taking a valid word does not wrap before the exit subtracts.
  assign occ_sum = {1'b0, occ_q} + (OCC_W+1)'(i_valid) - (OCC_W+1)'(vld_q[DEPTH-1]);

  always_ff @(posedge clk) begin
    if (sync_reset || i_flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RST_VAL;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else if (i_en) begin
      data_q[0] <= i_value;
      vld_q[0]  <= i_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k] <= data_q[k-1];
        vld_q[k]  <= vld_q[k-1];
      end
      occ_q <= occ_sum[OCC_W-1:0];
    end
  end

  assign o_valid     = vld_q[DEPTH-1];
  assign o_value     = data_q[DEPTH-1];
  assign o_occupancy = occ_q;

`ifdef DFF_PIPE_TAP_EN
  // Out-of-range selects fall through to the reset value.
  always_comb begin
    o_tap_value = RST_VAL;
    o_tap_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(i_tap_sel) == k) begin
        o_tap_value = data_q[k];
        o_tap_valid = vld_q[k];
      end
    end
  end
`endif

endmodule
